// File: rtl/div32bit_pkg.sv
// ============================================================================
// Module   : div32bit_pkg
// Brief    : Shared encodings and constants for the sequential divider.
// Revision : 1.0
// ============================================================================
`default_nettype none

package div32bit_pkg;

    // State encodings shared with the sequential multiplier
    localparam logic [1:0]  DIV_IDLE   = 2'd0;
    localparam logic [1:0]  DIV_RUN    = 2'd1;
    localparam logic [1:0]  DIV_DONE   = 2'd2;

    localparam int          DIV_STEPS  = 32;
    localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
    localparam logic [4:0]  DIV_LAST   = 5'(DIV_STEPS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = DIV_IDLE,
        ST_RUN  = DIV_RUN,
        ST_DONE = DIV_DONE
    } div_state_t;

endpackage

`default_nettype wire

// File: rtl/div32bit_if.sv
// ============================================================================
// Module   : div32bit_if
// Brief    : Start/busy/done handshake and operand/result bundle.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface div32bit_if;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

`default_nettype wire

// File: rtl/div32bit_div_step.sv
// ============================================================================
// Module   : div_step
// Brief    : One combinational restoring shift-subtract step.
// Revision : 1.0
// ============================================================================
`default_nettype none

module div_step
    import div32bit_pkg::*;
(
    input  wire logic [31:0] r,
    input  wire logic        q_msb,
    input  wire logic [31:0] d,
    output logic [32:0]      r_next,
    output logic             q_bit
);

    logic [32:0] w_shift;
    logic [32:0] w_diff;

    assign w_shift = {r, q_msb};
    assign w_diff  = w_shift - {1'b0, d};

    // A borrow out of bit 32 means the trial subtraction must be undone
    assign q_bit  = ~w_diff[32];
    assign r_next = w_diff[32] ? w_shift : w_diff;

endmodule

`default_nettype wire

// File: rtl/div32bit.sv
// ============================================================================
// Module   : div32bit
// Brief    : Multi-cycle unsigned 32-bit restoring divider, one bit per clock.
// Revision : 1.0
// ============================================================================
`default_nettype none

module div32bit
    import div32bit_pkg::*;
(
    input  wire logic  clk,
    input  wire logic  rst_n,
    div32bit_if.slave  bus
);

    div_state_t  r_state;
    div_state_t  w_next;
    logic        w_accept;

    logic [32:0] r_rem;
    logic [31:0] r_quo;
    logic [31:0] r_div;
    logic [4:0]  r_cnt;
    logic        r_dz;

    logic        r_busy;
    logic        r_done;
    logic [31:0] r_q_out;
    logic [31:0] r_r_out;
    logic        r_dz_out;

    logic [32:0] w_rem_next;
    logic        w_qbit;
    logic        w_unused_rem_msb;

    assign w_unused_rem_msb = r_rem[32];

    div_step u_step (
        .r      (r_rem[31:0]),
        .q_msb  (r_quo[31]),
        .d      (r_div),
        .r_next (w_rem_next),
        .q_bit  (w_qbit)
    );

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_accept = 1'b1;
                    w_next   = (bus.divisor == 32'd0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (r_cnt == DIV_LAST) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Q starts as the dividend and is shifted out as quotient bits shift in
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem <= 33'd0;
            r_quo <= 32'd0;
            r_div <= 32'd0;
            r_cnt <= 5'd0;
            r_dz  <= 1'b0;
        end else if (w_accept) begin
            r_rem <= 33'd0;
            r_quo <= bus.dividend;
            r_div <= bus.divisor;
            r_cnt <= 5'd0;
            r_dz  <= (bus.divisor == 32'd0);
        end else if (r_state == ST_RUN) begin
            r_rem <= w_rem_next;
            r_quo <= {r_quo[30:0], w_qbit};
            r_cnt <= r_cnt + 5'd1;
        end
    end

    // Outputs are registered one cycle behind the state; results hold until the next DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_q_out  <= 32'd0;
            r_r_out  <= 32'd0;
            r_dz_out <= 1'b0;
        end else begin
            r_busy <= (r_state == ST_RUN);
            r_done <= (r_state == ST_DONE);
            if (r_state == ST_DONE) begin
                // Zero divisor: Q was never shifted, so it still holds the dividend
                r_q_out  <= r_dz ? DIV_ZERO_Q : r_quo;
                r_r_out  <= r_dz ? r_quo : r_rem[31:0];
                r_dz_out <= r_dz;
            end
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.quotient    = r_q_out;
    assign bus.remainder   = r_r_out;
    assign bus.div_by_zero = r_dz_out;

endmodule

`default_nettype wire
